game_controller: RTL and testbench

Top-level sequencer for the Flappy Bird game. It turns the raw button and the collision flag into a play / die / game-over state machine. It generates the game tick that paces physics and obstacles, and drives the physics and score resets into the obstacle generator. It also keeps a session high score for the display.

---
 rtl/game_pkg.sv | 22 ++
 rtl/btn_edge.sv | 28 ++
 rtl/game_controller.sv | 165 ++++++++++++++++
 tb/tb_game_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, score width and default timing for the Flappy Bird sequencer.
package game_pkg;

  localparam int SCORE_W         = 7;
  localparam int TICK_DIV_DEF    = 100000;
  localparam int DEATH_TICKS_DEF = 64;
  localparam int BLINK_TICKS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Width of a counter that must hold modulus-1; stays legal for a modulus of 1.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Synchronizes an asynchronous button level and emits one clk pulse per rising edge.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // A held button keeps stage2 and stage3 equal, so only the edge produces a press.
  assign o_press = r_sync2 & ~r_sync3;

endmodule

// File: rtl/game_controller.sv
// Play / die / game-over sequencer: paces the game tick, drives physics and score
// resets, and keeps the session high score.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int DEATH_TICKS = DEATH_TICKS_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_pressed,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score,
  output logic               game_tick,
  output logic               phys_reset,
  output logic               score_reset,
  output logic               playing,
  output logic               game_over,
  output logic               blink,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);

  localparam int PRESC_W = cnt_width(TICK_DIV);
  localparam int DEATH_W = cnt_width(DEATH_TICKS);
  localparam int BLINK_W = cnt_width(BLINK_TICKS);

  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
  localparam logic [DEATH_W-1:0] DEATH_LOAD = DEATH_W'(DEATH_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_TICKS - 1);

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [DEATH_W-1:0] r_deathCnt;
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_gameTick;
  logic               r_physReset;
  logic               r_scoreReset;
  logic               r_playing;
  logic               r_gameOver;
  logic               r_blink;
  logic [SCORE_W-1:0] r_highScore;
  logic               r_newRecord;

  logic w_press;
  logic w_tickInt;

  btn_edge u_btn_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_pressed),
    .o_press (w_press)
  );

  // Free-running prescaler; never restarted by the state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign w_tickInt = (r_presc == PRESC_MAX);

  // The death counter holds the ticks still to come after the current one, so
  // the tick seen at zero is the last frozen tick and DEATH_TICKS fits its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_deathCnt   <= '0;
      r_blinkCnt   <= '0;
      r_gameTick   <= 1'b0;
      r_physReset  <= 1'b1;
      r_scoreReset <= 1'b0;
      r_playing    <= 1'b0;
      r_gameOver   <= 1'b0;
      r_blink      <= 1'b0;
      r_highScore  <= '0;
      r_newRecord  <= 1'b0;
    end else begin
      r_scoreReset <= 1'b0;
      r_gameTick   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state      <= ST_START;
            r_scoreReset <= 1'b1;
            r_newRecord  <= 1'b0;
            r_physReset  <= 1'b0;
          end
        end
        ST_START: begin
          r_state    <= ST_PLAY;
          r_playing  <= 1'b1;
          r_gameTick <= w_tickInt;
        end
        ST_PLAY: begin
          if (collision) begin
            r_state     <= ST_DYING;
            r_playing   <= 1'b0;
            r_physReset <= 1'b1;
            r_deathCnt  <= DEATH_LOAD;
            if (score > r_highScore) begin
              r_highScore <= score;
              r_newRecord <= 1'b1;
            end
          end else begin
            r_gameTick <= w_tickInt;
          end
        end
        ST_DYING: begin
          if (w_tickInt) begin
            if (r_deathCnt == '0) begin
              r_state    <= ST_OVER;
              r_gameOver <= 1'b1;
              r_blinkCnt <= '0;
              r_blink    <= 1'b0;
            end else begin
              r_deathCnt <= r_deathCnt - DEATH_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (w_press) begin
            r_state      <= ST_START;
            r_gameOver   <= 1'b0;
            r_blink      <= 1'b0;
            r_blinkCnt   <= '0;
            r_scoreReset <= 1'b1;
            r_newRecord  <= 1'b0;
            r_physReset  <= 1'b0;
          end else if (w_tickInt) begin
            if (r_blinkCnt == BLINK_MAX) begin
              r_blinkCnt <= '0;
              r_blink    <= ~r_blink;
            end else begin
              r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_physReset <= 1'b1;
          r_playing   <= 1'b0;
          r_gameOver  <= 1'b0;
          r_blink     <= 1'b0;
        end
      endcase
    end
  end

  assign game_tick   = r_gameTick;
  assign phys_reset  = r_physReset;
  assign score_reset = r_scoreReset;
  assign playing     = r_playing;
  assign game_over   = r_gameOver;
  assign blink       = r_blink;
  assign high_score  = r_highScore;
  assign new_record  = r_newRecord;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues expected output changes,
// a monitor compares them as the DUT presents them.
module tb_game_controller;

  localparam int TD = 4;
  localparam int DT = 3;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_pressed = 1'b0;
  logic       collision = 1'b0;
  logic [6:0] score = '0;
  logic       game_tick, phys_reset, score_reset, playing, game_over, blink, new_record;
  logic [6:0] high_score;

  typedef struct {
    string      name;
    int         cyc;
    logic       pl, go, pr, sr, nr;
    logic [6:0] hs;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   edgeCnt = 0;
  int   tickPhysViol = 0;
  bit   monEnable = 1'b0;
  logic [11:0] prevSnap;

  game_controller #(
    .TICK_DIV    (TD),
    .DEATH_TICKS (DT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_pressed (btn_pressed),
    .collision   (collision),
    .score       (score),
    .game_tick   (game_tick),
    .phys_reset  (phys_reset),
    .score_reset (score_reset),
    .playing     (playing),
    .game_over   (game_over),
    .blink       (blink),
    .high_score  (high_score),
    .new_record  (new_record)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      edgeCnt++;
    end
  end

  // Monitor: every change of the state-level outputs consumes one queued expectation.
  initial begin
    logic [11:0] curSnap;
    logic [11:0] expSnap;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (game_tick && phys_reset) tickPhysViol++;
      if (monEnable) begin
        curSnap = {playing, game_over, phys_reset, score_reset, new_record, high_score};
        if (curSnap != prevSnap) begin
          checks++;
          if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected cyc=%0d actual=%b required=no change", edgeCnt, curSnap);
          end else begin
            e = expQ.pop_front();
            expSnap = {e.pl, e.go, e.pr, e.sr, e.nr, e.hs};
            if (expSnap != curSnap || (e.cyc >= 0 && e.cyc != edgeCnt)) begin
              failures++;
              $display("[TB] FAIL sb_%s actual=%b@%0d required=%b@%0d (pl go pr sr nr hs)",
                       e.name, curSnap, edgeCnt, expSnap, e.cyc);
            end
          end
          prevSnap = curSnap;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", edgeCnt);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic b, input logic c, input logic [6:0] s);
    @(negedge clk);
    #1;
    btn_pressed = b;
    collision   = c;
    score       = s;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic pushExp(input string name, input int cyc, input logic pl, input logic go,
                         input logic pr, input logic sr, input logic nr, input logic [6:0] hs);
    exp_t e;
    e.name = name; e.cyc = cyc;
    e.pl = pl; e.go = go; e.pr = pr; e.sr = sr; e.nr = nr; e.hs = hs;
    expQ.push_back(e);
  endtask

  task automatic startGame(input logic [6:0] hsExp, input int hold, input bit measure);
    int n;
    int lastTick;
    int nTicks;
    applyStimulus(1'b1, 1'b0, score);
    n = edgeCnt;
    pushExp("start_sr", n + 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, hsExp);
    pushExp("start_play", n + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hsExp);
    lastTick = -1;
    nTicks = 0;
    for (int i = 1; i < hold; i++) begin
      applyStimulus(1'b1, 1'b0, score);
      if (measure && game_tick && playing) begin
        if (lastTick >= 0) checkOutput("tick_period", edgeCnt - lastTick, TD);
        lastTick = edgeCnt;
        nTicks++;
      end
    end
    if (measure) checkRange("tick_count", nTicks, 10, 13);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, score);
  endtask

  task automatic collide(input logic [6:0] sc, input logic nrExp, input logic [6:0] hsExp,
                         output int entry);
    applyStimulus(1'b0, 1'b0, sc);
    applyStimulus(1'b0, 1'b1, sc);
    entry = edgeCnt + 1;
    pushExp("collide", entry, 1'b0, 1'b0, 1'b1, 1'b0, nrExp, hsExp);
    applyStimulus(1'b0, 1'b0, sc);
    checkOutput("dying_tick", int'(game_tick), 0);
  endtask

  task automatic waitOver(input int entry, input bit pressInDying, input logic nrExp,
                          input logic [6:0] hsExp);
    bit seen;
    pushExp("over", -1, 1'b0, 1'b1, 1'b1, 1'b0, nrExp, hsExp);
    if (pressInDying) begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, score);
      applyStimulus(1'b0, 1'b0, score);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (game_over) seen = 1'b1;
    end
    checkOutput("over_reached", int'(seen), 1);
    if (seen) checkRange("death_len", edgeCnt - entry, (DT - 1) * TD + 1, DT * TD);
  endtask

  initial begin
    int entry;
    int toggles[$];
    logic prevBlink;
    int idleTicks;
    int idlePhysLow;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_phys_reset", int'(phys_reset), 1);
    checkOutput("rst_playing", int'(playing), 0);
    checkOutput("rst_game_tick", int'(game_tick), 0);
    checkOutput("rst_score_reset", int'(score_reset), 0);
    checkOutput("rst_high_score", int'(high_score), 0);
    prevSnap = 12'b001_00_0000000;
    monEnable = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    idleTicks = 0;
    idlePhysLow = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (game_tick) idleTicks++;
      if (!phys_reset) idlePhysLow++;
    end
    checkOutput("idle_ticks", idleTicks, 0);
    checkOutput("idle_phys_low", idlePhysLow, 0);

    // Game 1: held button, tick period, then collision with a same-cycle press.
    startGame(7'd0, 50, 1'b1);
    applyStimulus(1'b1, 1'b0, 7'd12);
    applyStimulus(1'b1, 1'b0, 7'd12);
    applyStimulus(1'b1, 1'b1, 7'd12);
    entry = edgeCnt + 1;
    pushExp("collide_press", entry, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd12);
    applyStimulus(1'b0, 1'b0, 7'd12);
    checkOutput("dying_tick_g1", int'(game_tick), 0);
    applyStimulus(1'b0, 1'b0, 7'd12);
    waitOver(entry, 1'b1, 1'b1, 7'd12);

    prevBlink = blink;
    for (int i = 0; i < 30 && toggles.size() < 3; i++) begin
      @(negedge clk);
      if (blink != prevBlink) toggles.push_back(edgeCnt);
      prevBlink = blink;
    end
    checkOutput("blink_toggles", toggles.size(), 3);
    if (toggles.size() == 3) begin
      checkOutput("blink_half1", toggles[1] - toggles[0], BT * TD);
      checkOutput("blink_half2", toggles[2] - toggles[1], BT * TD);
    end

    // Game 2: lower score keeps the record.
    startGame(7'd12, 6, 1'b0);
    checkOutput("blink_after_start", int'(blink), 0);
    collide(7'd5, 1'b0, 7'd12, entry);
    waitOver(entry, 1'b0, 1'b0, 7'd12);

    // Game 3: equal score is not a new record.
    startGame(7'd12, 6, 1'b0);
    collide(7'd12, 1'b0, 7'd12, entry);
    waitOver(entry, 1'b0, 1'b0, 7'd12);

    // Game 4: reset while playing.
    startGame(7'd12, 6, 1'b0);
    applyStimulus(1'b0, 1'b0, 7'd20);
    rst_n = 1'b0;
    pushExp("mid_reset", edgeCnt + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    #1;
    checkOutput("mreset_playing", int'(playing), 0);
    checkOutput("mreset_phys_reset", int'(phys_reset), 1);
    checkOutput("mreset_high_score", int'(high_score), 0);
    checkOutput("mreset_game_tick", int'(game_tick), 0);
    checkOutput("mreset_game_over", int'(game_over), 0);
    checkOutput("mreset_blink", int'(blink), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    checkOutput("sb_drain", expQ.size(), 0);
    checkOutput("tick_vs_phys", tickPhysViol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
